cla_multiword_adder: RTL and testbench
======================================

// Module: cla_multiword_adder
// PURPOSE
//   Sequential wide adder built around the team's 16-bit carry-lookahead adder slice.
//   Accepts two WORDS*16-bit operands and a carry-in over a valid/ready handshake.
//   Adds one 16-bit slice per cycle, least-significant slice first, rippling the slice carry through a register.
//   Returns the full sum and carry-out over a second valid/ready handshake.
//   Sits directly upstream and downstream of the 16-bit adder slice: it drives the slice's a/b/cin and consumes its sum/cout.
// PARAMETERS
//   WORDS  4  number of 16-bit slices; operand width W = 16*WORDS; legal range 1..16
// PORTS
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   synchronous, active-low reset
//   in_valid   in   1   operands present on in_a/in_b/in_cin
//   in_ready   out  1   block can accept operands
//   in_a       in   W   operand A
//   in_b       in   W   operand B
//   in_cin     in   1   carry-in to slice 0
//   out_valid  out  1   result valid
//   out_ready  in   1   consumer accepts result
//   out_sum    out  W   (in_a + in_b + in_cin) mod 2^W
//   out_cout   out  1   carry out of the top slice
// BEHAVIOUR
//   - Reset (rst_n low at a clk edge):
//       state=IDLE, slice index=0, carry reg=0, out_valid=0, out_sum=0, out_cout=0.
//       Any operation in flight is discarded; no output is produced for it.
//       While rst_n is low, in_valid is ignored.
//   - FSM states IDLE, ADD and DONE:
//       IDLE: in_ready=1. On in_valid&in_ready: capture in_a and in_b into operand regs, carry<=in_cin, idx<=0, go to ADD.
//       ADD: in_ready=0. Slice inputs are a[idx*16+:16], b[idx*16+:16] and carry.
//            sum_reg[idx*16+:16] <= slice sum; carry <= slice cout.
//            If idx==WORDS-1, go to DONE; else idx<=idx+1.
//       DONE: out_valid=1; out_sum=sum_reg; out_cout=carry. All three are held stable until out_ready.
//             On out_ready, go to IDLE and drop out_valid on the next cycle.
//   - Latency: out_valid rises exactly WORDS cycles after the accepting edge.
//   - Throughput: at most one operation per WORDS+2 cycles. No overlap: in_ready=0 in ADD and DONE.
//   - Operands captured at acceptance. Later changes on in_a/in_b/in_cin do not affect the in-flight result.
//   - out_sum and out_cout are registered; no combinational path from in_* to out_*.
//   - Wrap-around: carry out of the top slice appears only on out_cout; out_sum wraps modulo 2^W.
//   - WORDS==1: a single ADD cycle; out_valid one cycle after acceptance.
//   - out_ready held high with no valid result: no effect.
//   - in_valid held high while busy: no effect; the operation is accepted on the next IDLE cycle.
// CONFIGURATION
//   - Macro CLA_MW_OVF_EN, when defined:
//       Adds output port out_ovf (1 bit).
//       out_ovf = two's-complement signed overflow = carry into MSB XOR carry out of MSB, computed in the last ADD cycle.
//       Registered; reset 0; valid and held with out_valid.
//   - Macro not defined: out_ovf port and its logic are absent; all other behaviour is identical.
// STRUCTURE
//   - Shared package cla_pkg:
//       SLICE_W=16
//       state enum {IDLE, ADD, DONE}
//       function clog2 for idx width: max(1, clog2(WORDS))
//   - One sub-module: carry_look_ahead_16bit, instantiated once as the slice datapath.
//   - Everything else (FSM, operand/sum registers, slice mux) is in this module.
// TESTING
//   - Reset mid-op: accept A=1,B=1, assert rst_n=0 during ADD -> out_valid stays 0; state IDLE; in_ready=1 after release.
//   - Basic: WORDS=4, A=0x0000_0000_0000_0005, B=0x...0003, cin=0 -> after 4 cycles out_sum=0x...0008, out_cout=0.
//   - Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0, out_cout=1, latency exactly 4 cycles.
//   - Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_sum stable; in_ready=0; second in_valid not accepted until handoff.
//   - Operand change: change in_a the cycle after acceptance -> result reflects the captured value; WORDS=1 build gives latency 1.
//   - CLA_MW_OVF_EN: A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> out_ovf=1, out_cout=0; A=B=0x8000_0000_0000_0000 -> out_ovf=1, out_cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants, FSM state type and index-width helper for the multiword CLA adder
package cla_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a single-slice build still has a usable index register.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/carry_look_ahead_16bit.sv
// rtl/carry_look_ahead_16bit.sv - 16-bit adder slice with 4-bit group generate/propagate lookahead
module carry_look_ahead_16bit
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;
  logic [3:0]         grp_g;
  logic [3:0]         grp_p;
  logic [4:0]         grp_c;

  always_comb begin
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p[4*k +: 4];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (&p[4*k+2 +: 2] & g[4*k+1])
               | (&p[4*k+1 +: 3] & g[4*k]);
    end
    // Group carries come from the lookahead terms, not from the bit carries.
    grp_c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = grp_c[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[SLICE_W] = grp_c[4];
  end

  assign sum  = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];

endmodule

// File: rtl/cla_multiword_adder.sv
// rtl/cla_multiword_adder.sv - sequential WORDS*16-bit adder, one CLA slice per cycle; CLA_MW_OVF_EN adds out_ovf
module cla_multiword_adder
  import cla_pkg::*;
#(
  parameter int WORDS = 4,
  localparam int W    = SLICE_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
`ifdef CLA_MW_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int IW = clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t state, state_next;
  logic [IW-1:0]                   idx;
  logic                            carry;
  logic [WORDS-1:0][SLICE_W-1:0]   a_reg;
  logic [WORDS-1:0][SLICE_W-1:0]   b_reg;
  logic [WORDS-1:0][SLICE_W-1:0]   sum_reg;
  logic [SLICE_W-1:0]              slice_sum;
  logic                            slice_cout;
`ifdef CLA_MW_OVF_EN
  logic                            ovf_reg;
`endif

  carry_look_ahead_16bit u_slice (
    .a    (a_reg[idx]),
    .b    (b_reg[idx]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ADD;
      end
      ADD: begin
        if (idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
`ifdef CLA_MW_OVF_EN
      ovf_reg <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_cin;
            idx   <= '0;
          end
        end
        ADD: begin
          sum_reg[idx] <= slice_sum;
          carry        <= slice_cout;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
`ifdef CLA_MW_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          if (idx == LAST_IDX)
            ovf_reg <= (a_reg[idx][SLICE_W-1] ^ b_reg[idx][SLICE_W-1] ^ slice_sum[SLICE_W-1]) ^ slice_cout;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry;
`ifdef CLA_MW_OVF_EN
  assign out_ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_cla_multiword_adder.sv
// tb/tb_cla_multiword_adder.sv - randomized self-checking bench for cla_multiword_adder against an arithmetic model
module tb_cla_multiword_adder;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CLA_MW_OVF_EN
  logic         out_ovf;
`endif

  int checks;
  int errors;
  logic last_ovf;

  cla_multiword_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CLA_MW_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    s = model_sum(a, b, cin);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < WORDS; i++) v[i*16 +: 16] = 16'($urandom);
    return v;
  endfunction

  // Full handshake: present operands, wait acceptance, count cycles to out_valid, consume result.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [W-1:0] s, output logic c, output int lat);
    int guard;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    s = out_sum;
    c = out_cout;
`ifdef CLA_MW_OVF_EN
    last_ovf = out_ovf;
`else
    last_ovf = 1'b0;
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = '1; in_b = '1; in_cin = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got=%h exp=0", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got=%b exp=0", out_cout); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < WORDS + 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ignored_valid cyc=%0d got=%b exp=0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    in_a = W'(1); in_b = W'(1); in_cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < WORDS + 2; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic c; int lat;
    run_op(W'(5), W'(3), 1'b0, s, c, lat);
    checks++; if (s !== W'(8)) begin errors++; $display("FAIL basic_sum got=%h exp=%h", s, W'(8)); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL basic_cout got=%b exp=0", c); end
    checks++; if (lat !== WORDS) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, WORDS); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_ripple();
    logic [W-1:0] s; logic c; int lat;
    run_op({W{1'b1}}, '0, 1'b1, s, c, lat);
    checks++; if (s !== '0) begin errors++; $display("FAIL ripple_sum got=%h exp=0", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL ripple_cout got=%b exp=1", c); end
    checks++; if (lat !== WORDS) begin errors++; $display("FAIL ripple_latency got=%0d exp=%0d", lat, WORDS); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a1, b1, a2, b2; logic c1, c2; logic [W:0] e1, e2; int lat;
    a1 = rand_word(); b1 = rand_word(); c1 = 1'($urandom);
    a2 = rand_word(); b2 = rand_word(); c2 = 1'($urandom);
    e1 = model_sum(a1, b1, c1); e2 = model_sum(a2, b2, c2);
    in_a = a1; in_b = b1; in_cin = c1; in_valid = 1'b1;
    tick();
    in_a = a2; in_b = b2; in_cin = c2;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    checks++; if (lat !== WORDS) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, WORDS); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_sum !== e1[W-1:0] || out_cout !== e1[W] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b s=%h c=%b r=%b exp v=1 s=%h c=%b r=0",
                 i, out_valid, out_sum, out_cout, in_ready, e1[W-1:0], e1[W]);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_handoff got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    checks++; if (out_sum !== e2[W-1:0] || out_cout !== e2[W] || lat !== WORDS) begin
      errors++; $display("FAIL bp_second got s=%h c=%b lat=%0d exp s=%h c=%b lat=%0d", out_sum, out_cout, lat, e2[W-1:0], e2[W], WORDS);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_operand_change();
    logic [W-1:0] a, b; logic c; logic [W:0] e; int lat;
    a = rand_word(); b = rand_word(); c = 1'($urandom);
    e = model_sum(a, b, c);
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_a = ~a; in_b = rand_word(); in_cin = ~c;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    checks++; if (out_sum !== e[W-1:0] || out_cout !== e[W] || lat !== WORDS) begin
      errors++; $display("FAIL opchg got s=%h c=%b lat=%0d exp s=%h c=%b lat=%0d", out_sum, out_cout, lat, e[W-1:0], e[W], WORDS);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s; logic c, co; logic [W:0] e; int lat;
    for (int n = 0; n < 40; n++) begin
      a = rand_word(); b = rand_word(); c = 1'($urandom);
      if (n % 8 == 0) a = {W{1'b1}};
      if (n % 8 == 1) b = {W{1'b1}};
      e = model_sum(a, b, c);
      run_op(a, b, c, s, co, lat);
      checks++; if (s !== e[W-1:0] || co !== e[W] || lat !== WORDS) begin
        errors++; $display("FAIL rand[%0d] got s=%h c=%b lat=%0d exp s=%h c=%b lat=%0d", n, s, co, lat, e[W-1:0], e[W], WORDS);
      end
`ifdef CLA_MW_OVF_EN
      checks++; if (last_ovf !== model_ovf(a, b, c)) begin
        errors++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", n, last_ovf, model_ovf(a, b, c));
      end
`endif
    end
  endtask

`ifdef CLA_MW_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] s, mx, mn; logic c; int lat;
    mx = {1'b0, {(W-1){1'b1}}};
    mn = {1'b1, {(W-1){1'b0}}};
    run_op(mx, W'(1), 1'b0, s, c, lat);
    checks++; if (last_ovf !== 1'b1 || c !== 1'b0) begin
      errors++; $display("FAIL ovf_pos got ovf=%b c=%b exp ovf=1 c=0", last_ovf, c);
    end
    run_op(mn, mn, 1'b0, s, c, lat);
    checks++; if (last_ovf !== 1'b1 || c !== 1'b1 || s !== '0) begin
      errors++; $display("FAIL ovf_neg got ovf=%b c=%b s=%h exp ovf=1 c=1 s=0", last_ovf, c, s);
    end
  endtask
`endif

  initial begin
    checks = 0; errors = 0; last_ovf = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_ripple();
    test_backpressure();
    test_operand_change();
    test_reset_mid_op();
    test_random();
`ifdef CLA_MW_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
